mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Sits in the EXECUTE stage beside the ALU and implements MULT, MULTU, DIV and DIVU.
- Runs as a multi-cycle operation and reports busy/done, which the pipeline control uses to stall.
- Extends the single-cycle datapath with a variable-latency arithmetic mode.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- opA  input  WIDTH  multiplicand / dividend
- opB  input  WIDTH  multiplier / divisor
- flush  input  1  abort the in-flight operation (branch taken / squash)
- hiWrite  input  1  MTHI: HI <= wrData (IDLE only)
- loWrite  input  1  MTLO: LO <= wrData (IDLE only)
- wrData  input  WIDTH  data for hiWrite/loWrite
- busy  output  1  operation in progress; pipeline stalls on MFHI/MFLO and any new start
- done  output  1  one-cycle pulse; HI/LO hold the new result
- divByZero  output  1  sticky flag for the last completed op; set by a DIV/DIVU with opB = 0
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, divByZero = 0, state IDLE, iteration counter 0.
- Reset has priority over every other input, including mid-operation.
- States are IDLE, CALC and FIX.

IDLE:
- On start = 1 and flush = 0, the unit latches op.
- It latches |opA| and |opB| (two's-complement magnitude for signed ops, raw value for unsigned ops).
- It latches the result signs: product sign = signA ^ signB; quotient sign = signA ^ signB; remainder sign = signA.
- Counter <= 0; next state CALC; busy = 1 from the following cycle.
- DIV/DIVU with opB = 0 skips CALC and goes straight to FIX with divide-by-zero marked.

CALC (one iteration per cycle, WIDTH cycles):
- Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
- Divide: restoring shift-subtract; quotient bit = 1 when the partial remainder >= divisor.
- After iteration WIDTH-1, go to FIX.

FIX (one cycle):
- Apply the latched signs (negate as required) and write HI/LO.
- Update divByZero: 1 if this op was a divide by zero, else 0.
- On divide by zero: lo = all ones, hi = opA unchanged.
- Next state IDLE; busy = 0 and done = 1 in the cycle after FIX.

Latency:
- Normal operation: done asserts WIDTH+2 cycles after the start edge.
- Divide by zero: done asserts 2 cycles after the start edge.

Handshake and boundary rules:
- start while busy: ignored.
- start in the same cycle as done: accepted (the unit is in IDLE).
- flush in any state: next state IDLE, busy = 0, no done pulse; HI, LO and divByZero are unchanged.
- flush and start together: flush wins and start is ignored.
- hiWrite/loWrite while busy: ignored.
- hiWrite/loWrite in IDLE together with start: the write takes effect and is later overwritten by the result.
- hiWrite and loWrite together: both registers are written.
- Signed overflow (MIN / -1): lo = MIN, hi = 0; no flag.
- Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- All arithmetic wraps modulo 2^WIDTH per half.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC early once the remaining unprocessed multiplier bits are all zero; the remaining shifts are applied in one step in FIX.
  - Latency is then (index of the highest set bit of |opB|) + 3 cycles; |opB| = 0 gives 2 cycles.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+2 latency for every non-zero-divisor operation.
- Results are bit-identical either way.

Test Plan:
- MULTU opA = 0xFFFFFFFF, opB = 0xFFFFFFFF -> done at cycle 34; hi = 0xFFFFFFFE, lo = 0x00000001; busy high cycles 1..33.
- MULT opA = -3, opB = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
- DIV opA = -7, opB = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), divByZero = 0.
- DIVU opA = 0x1234, opB = 0 -> done at cycle 2, lo = 0xFFFFFFFF, hi = 0x1234, divByZero = 1. A following DIVU 10/3 -> lo = 3, hi = 1, divByZero = 0.
- Start MULTU 5*5, flush at cycle 10 -> no done; hi/lo keep prior values; busy = 0 at cycle 11. A new start at cycle 11 completes normally.
- loWrite wrData = 0xA5 in IDLE -> lo = 0xA5. Repeat with busy = 1 and start pulsed -> lo unchanged and start ignored. With MDU_EARLY_OUT_EN: MULTU 9*1 -> done at cycle 3, lo = 9.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EXECUTE stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] wrData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opA, opB, flush, hiWrite, loWrite, wrData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, flush, hiWrite, loWrite, wrData,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (shift-add / restoring divide).
// Optional MDU_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} mduState_t;

  mduState_t        state, stateNext;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] rawA;
  logic             isDiv, negLo, negHi, divZero;
  logic             busyQ, doneQ, dbzQ;
  logic [WIDTH-1:0] hiQ, loQ;
`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] mRem;
`endif

  // operand decode for a new request
  logic             opIsDiv, isSigned, signA, signB;
  logic [WIDTH-1:0] magA, magB;
  always_comb begin
    opIsDiv  = bus.op[1];
    isSigned = ~bus.op[0];
    signA    = isSigned & bus.opA[WIDTH-1];
    signB    = isSigned & bus.opB[WIDTH-1];
    magA     = signA ? -bus.opA : bus.opA;
    magB     = signB ? -bus.opB : bus.opB;
  end

  // one shift-add or restoring shift-subtract step
  logic [WIDTH:0]   mulSum, remShift;
  logic [WIDTH-1:0] remNext;
  logic             remGeq, lastIter;
  logic [AW-1:0]    accStep;
  always_comb begin
    mulSum   = {1'b0, acc[AW-1:WIDTH]} + {1'b0, operand};
    remShift = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    remGeq   = remShift >= {1'b0, operand};
    remNext  = remGeq ? WIDTH'(remShift - {1'b0, operand}) : remShift[WIDTH-1:0];
    if (isDiv) begin
      accStep = {remNext, acc[WIDTH-2:0], remGeq};
    end else if (acc[0]) begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end else begin
      accStep = {1'b0, acc[AW-1:1]};
    end
    lastIter = (cnt == CW'(WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
    if (!isDiv && mRem[WIDTH-1:1] == '0) lastIter = 1'b1;
`endif
  end

  // sign fix-up and result selection
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quo, remd, hiRes, loRes;
  always_comb begin
    prod = acc;
`ifdef MDU_EARLY_OUT_EN
    // catch up on the shifts skipped by leaving CALC early
    prod = acc >> (CW'(WIDTH) - cnt);
`endif
    if (negLo) prod = -prod;
    quo  = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remd = negHi ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
    if (divZero) begin
      hiRes = rawA;
      loRes = '1;
    end else if (isDiv) begin
      hiRes = remd;
      loRes = quo;
    end else begin
      hiRes = prod[AW-1:WIDTH];
      loRes = prod[WIDTH-1:0];
    end
  end

  // next-state logic; flush always returns to IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (opIsDiv && bus.opB == '0) stateNext = FIX;
`ifdef MDU_EARLY_OUT_EN
          else if (!opIsDiv && magB == '0) stateNext = FIX;
`endif
          else stateNext = CALC;
        end
      end
      CALC:    if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.flush) stateNext = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      rawA    <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      dbzQ    <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
`ifdef MDU_EARLY_OUT_EN
      mRem    <= '0;
`endif
    end else begin
      state <= stateNext;
      busyQ <= (stateNext != IDLE);
      doneQ <= (state == FIX) && !bus.flush;
      case (state)
        IDLE: begin
          if (bus.hiWrite) hiQ <= bus.wrData;
          if (bus.loWrite) loQ <= bus.wrData;
          if (bus.start && !bus.flush) begin
            isDiv   <= opIsDiv;
            negLo   <= signA ^ signB;
            negHi   <= signA;
            rawA    <= bus.opA;
            operand <= opIsDiv ? magB : magA;
            acc     <= {WIDTH'(0), opIsDiv ? magA : magB};
            cnt     <= '0;
            divZero <= opIsDiv && (bus.opB == '0);
`ifdef MDU_EARLY_OUT_EN
            mRem    <= magB;
`endif
          end
        end
        CALC: begin
          acc <= accStep;
          cnt <= cnt + CW'(1);
`ifdef MDU_EARLY_OUT_EN
          mRem <= mRem >> 1;
`endif
        end
        FIX: begin
          if (!bus.flush) begin
            hiQ  <= hiRes;
            loQ  <= loRes;
            dbzQ <= divZero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.divByZero = dbzQ;
  assign bus.hi        = hiQ;
  assign bus.lo        = loQ;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: result table plus flush/reset/HI-LO write sequences.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam int LIMIT = 100;
`ifdef MDU_EARLY_OUT_EN
  localparam int FLUSH_CYC = 3;
`else
  localparam int FLUSH_CYC = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vecT;

  vecT vec[14];
  int  nCmp = 0;
  int  nFail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic int expLat(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
`endif
    if (o[1]) return (b == 32'h0) ? 2 : W + 2;
`ifdef MDU_EARLY_OUT_EN
    m = (!o[0] && b[31]) ? -b : b;
    if (m == 32'h0) return 2;
    for (int i = 31; i >= 0; i--) if (m[i]) return i + 3;
`endif
    return W + 2;
  endfunction

  // called at a negedge; start is sampled by the following posedge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCyc);
    lat = 1;
    busyCyc = 0;
    while (!bus.done && lat < LIMIT) begin
      if (bus.busy) busyCyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, busyCyc;
  bit sawDone;

  initial begin
    vec[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vec[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vec[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vec[3]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vec[4]  = '{2'b11, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0};
    vec[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vec[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vec[7]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vec[8]  = '{2'b01, 32'h00000009, 32'h00000001, 32'h00000000, 32'h00000009, 1'b0};
    vec[9]  = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vec[10] = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vec[11] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vec[12] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vec[13] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.opA = '0; bus.opB = '0;
    bus.flush = 1'b0; bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.wrData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_dbz", 64'(bus.divByZero), 64'h0);

    // back-to-back: each new start lands in the same cycle as the previous done
    for (int i = 0; i < 14; i++) begin
      issue(vec[i].op, vec[i].a, vec[i].b);
      waitDone(lat, busyCyc);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(expLat(vec[i].op, vec[i].b)));
      check($sformatf("v%0d_busycyc", i), 64'(busyCyc), 64'(expLat(vec[i].op, vec[i].b) - 1));
      check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'h0);
      check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vec[i].hi));
      check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vec[i].lo));
      check($sformatf("v%0d_dbz", i), 64'(bus.divByZero), 64'(vec[i].dbz));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'h0);

    // MTHI+MTLO together, then flush a multiply
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.wrData = 32'h77;
    @(negedge clk);
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    check("both_wr_hi", 64'(bus.hi), 64'h77);
    check("both_wr_lo", 64'(bus.lo), 64'h77);
    issue(2'b01, 32'd5, 32'd5);
    repeat (FLUSH_CYC - 1) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'h0);
    check("flush_done", 64'(bus.done), 64'h0);
    check("flush_hi", 64'(bus.hi), 64'h77);
    check("flush_lo", 64'(bus.lo), 64'h77);
    issue(2'b01, 32'd5, 32'd5);
    waitDone(lat, busyCyc);
    check("post_flush_lat", 64'(lat), 64'(expLat(2'b01, 32'd5)));
    check("post_flush_lo", 64'(bus.lo), 64'd25);
    @(negedge clk);

    // flush together with start: start loses
    bus.flush = 1'b1;
    issue(2'b01, 32'd3, 32'd3);
    bus.flush = 1'b0;
    check("flush_start_busy", 64'(bus.busy), 64'h0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    check("flush_start_nodone", 64'(sawDone), 64'h0);
    check("flush_start_lo", 64'(bus.lo), 64'd25);

    // MTLO in IDLE, then MTLO and start while busy are ignored
    bus.loWrite = 1'b1; bus.wrData = 32'hA5;
    @(negedge clk);
    bus.loWrite = 1'b0;
    check("mtlo_idle", 64'(bus.lo), 64'hA5);
    issue(2'b01, 32'd2, 32'd3);
    bus.loWrite = 1'b1; bus.wrData = 32'h5A;
    issue(2'b01, 32'd100, 32'd100);
    bus.loWrite = 1'b0;
    check("mtlo_busy_ignored", 64'(bus.lo), 64'hA5);
    lat = 2;
    busyCyc = 0;
    while (!bus.done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_lat", 64'(lat), 64'(expLat(2'b01, 32'd3)));
    check("busy_start_lo", 64'(bus.lo), 64'd6);
    @(negedge clk);
    check("busy_start_not_queued", 64'(bus.busy), 64'h0);

    // MTHI together with start: result overwrites the written value
    bus.hiWrite = 1'b1; bus.wrData = 32'hDEAD;
    issue(2'b01, 32'h80000000, 32'd4);
    bus.hiWrite = 1'b0;
    check("mthi_with_start", 64'(bus.hi), 64'hDEAD);
    waitDone(lat, busyCyc);
    check("mthi_overwritten_hi", 64'(bus.hi), 64'h2);
    check("mthi_overwritten_lo", 64'(bus.lo), 64'h0);

    // reset mid-operation
    issue(2'b11, 32'd100, 32'd0);
    @(negedge clk);
    check("dbz_set", 64'(bus.divByZero), 64'h1);
    issue(2'b01, 32'hFFFFFFFF, 32'd2);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'h0);
    check("midrst_hi", 64'(bus.hi), 64'h0);
    check("midrst_lo", 64'(bus.lo), 64'h0);
    check("midrst_dbz", 64'(bus.divByZero), 64'h0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    check("midrst_nodone", 64'(sawDone), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end
endmodule
